// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings for the slave response multiplexer and its default slave.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        D_IDLE,
        D_ERR1,
        D_ERR2
    } dflt_state_t;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: answers unmapped/multi-hot active transfers with the two-cycle ERROR response.
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic h_clk,
    input  logic h_reset,
    input  logic start,
    input  logic accept,
    output logic ready,
    output logic resp
);

    dflt_state_t state;

    // Outputs are registered alongside the state so they follow it exactly.
    always_ff @(posedge h_clk) begin
        if (h_reset) begin
            state <= D_IDLE;
            ready <= 1'b1;
            resp  <= HRESP_OKAY;
        end else begin
            case (state)
                D_IDLE: begin
                    if (start && accept) begin
                        state <= D_ERR1;
                        ready <= 1'b0;
                        resp  <= HRESP_ERROR;
                    end
                end
                D_ERR1: begin
                    state <= D_ERR2;
                    ready <= 1'b1;
                    resp  <= HRESP_ERROR;
                end
                D_ERR2: begin
                    if (start && accept) begin
                        state <= D_ERR1;
                        ready <= 1'b0;
                        resp  <= HRESP_ERROR;
                    end else begin
                        state <= D_IDLE;
                        ready <= 1'b1;
                        resp  <= HRESP_OKAY;
                    end
                end
                default: begin
                    state <= D_IDLE;
                    ready <= 1'b1;
                    resp  <= HRESP_OKAY;
                end
            endcase
        end
    end

endmodule

// File: rtl/ahb_slave_mux_n.sv
// AHB-Lite slave-to-master response mux with data-phase select register,
// built-in default slave and saturating error counter.
module ahb_slave_mux_n
    import ahb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLV    = 5,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                                h_clk,
    input  logic                                h_reset,
    input  logic [NUM_SLV-1:0]                  h_sel_x,
    input  logic [1:0]                          h_trans,
    input  logic [NUM_SLV-1:0]                  h_ready_x,
    input  logic [NUM_SLV-1:0]                  h_resp_x,
    input  logic [NUM_SLV-1:0][DATA_WIDTH-1:0]  h_rdata_x,
    input  logic                                err_clr,
    output logic [DATA_WIDTH-1:0]               h_rdata,
    output logic                                h_ready,
    output logic                                h_resp,
    output logic [ERR_CNT_W-1:0]                err_count
);

    logic [NUM_SLV-1:0] dp_sel;
    logic               any_sel;
    logic               multi_sel;
    logic               one_hot;
    logic               active;
    logic               dflt;
    logic               ds_ready;
    logic               ds_resp;
    htrans_t            trans;

    assign trans  = htrans_t'(h_trans);
    assign active = (trans == NONSEQ) || (trans == SEQ);

    always_comb begin
        any_sel   = 1'b0;
        multi_sel = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (h_sel_x[i]) begin
                if (any_sel)
                    multi_sel = 1'b1;
                any_sel = 1'b1;
            end
        end
    end

    assign one_hot = any_sel && !multi_sel;
    assign dflt    = active && !one_hot;

    // Only a clean one-hot select reaches the data phase; anything else leaves dp_sel empty.
    always_ff @(posedge h_clk) begin
        if (h_reset)
            dp_sel <= '0;
        else if (h_ready)
            dp_sel <= one_hot ? h_sel_x : '0;
    end

    ahb_default_slave u_dflt (
        .h_clk   (h_clk),
        .h_reset (h_reset),
        .start   (dflt),
        .accept  (h_ready),
        .ready   (ds_ready),
        .resp    (ds_resp)
    );

    always_comb begin
        h_ready = ds_ready;
        h_resp  = ds_resp;
        h_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (dp_sel[i]) begin
                h_ready = h_ready_x[i];
                h_resp  = h_resp_x[i];
                h_rdata = h_rdata_x[i];
            end
        end
        if (h_reset) begin
            h_ready = 1'b1;
            h_resp  = HRESP_OKAY;
            h_rdata = '0;
        end
    end

    always_ff @(posedge h_clk) begin
        if (h_reset || err_clr)
            err_count <= '0;
        else if (h_ready && (h_resp == HRESP_ERROR) && (err_count != '1))
            err_count <= err_count + 1'b1;
    end

endmodule

// File: tb/tb_ahb_slave_mux_n.sv
// Directed bench for ahb_slave_mux_n: expected data-phase responses are queued as each
// cycle is driven and compared mid-cycle; error counters checked after each edge.
module tb_ahb_slave_mux_n;
    import ahb_pkg::*;

    localparam int DW = 32;
    localparam int NS = 5;
    localparam logic [NS-1:0] ALL = '1;
    localparam logic [31:0] RD3 = 32'h1000_0003;
    localparam logic [31:0] RD4 = 32'h1000_0004;

    typedef struct {
        logic        rdy;
        logic        resp;
        logic [31:0] rd;
    } exp_t;

    logic                   h_clk = 1'b0;
    logic                   h_reset;
    logic [NS-1:0]          h_sel_x;
    logic [1:0]             h_trans;
    logic [NS-1:0]          h_ready_x;
    logic [NS-1:0]          h_resp_x;
    logic [NS-1:0][DW-1:0]  h_rdata_x;
    logic                   err_clr;
    logic [DW-1:0]          h_rdata,  h_rdata2;
    logic                   h_ready,  h_ready2;
    logic                   h_resp,   h_resp2;
    logic [7:0]             err_count;
    logic [1:0]             err_count2;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 h_clk = ~h_clk;

    ahb_slave_mux_n #(.DATA_WIDTH(DW), .NUM_SLV(NS), .ERR_CNT_W(8)) dut (
        .h_clk(h_clk), .h_reset(h_reset), .h_sel_x(h_sel_x), .h_trans(h_trans),
        .h_ready_x(h_ready_x), .h_resp_x(h_resp_x), .h_rdata_x(h_rdata_x), .err_clr(err_clr),
        .h_rdata(h_rdata), .h_ready(h_ready), .h_resp(h_resp), .err_count(err_count)
    );

    ahb_slave_mux_n #(.DATA_WIDTH(DW), .NUM_SLV(NS), .ERR_CNT_W(2)) dut2 (
        .h_clk(h_clk), .h_reset(h_reset), .h_sel_x(h_sel_x), .h_trans(h_trans),
        .h_ready_x(h_ready_x), .h_resp_x(h_resp_x), .h_rdata_x(h_rdata_x), .err_clr(err_clr),
        .h_rdata(h_rdata2), .h_ready(h_ready2), .h_resp(h_resp2), .err_count(err_count2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cnt(input string tag, input logic [7:0] e8, input logic [1:0] e2);
        chk({tag, ".cnt8"}, {24'h0, err_count}, {24'h0, e8});
        chk({tag, ".cnt2"}, {30'h0, err_count2}, {30'h0, e2});
    endtask

    // Drive one cycle (next address phase + this data phase's slave responses), then check.
    task automatic step(input string tag, input logic [NS-1:0] sel, input logic [1:0] tr,
                        input logic [NS-1:0] rx, input logic [NS-1:0] px,
                        input logic rst, input logic clr,
                        input logic er, input logic ep, input logic [31:0] ed);
        exp_t e;
        h_sel_x   = sel;
        h_trans   = tr;
        h_ready_x = rx;
        h_resp_x  = px;
        h_reset   = rst;
        err_clr   = clr;
        sb.push_back('{rdy: er, resp: ep, rd: ed});
        @(negedge h_clk);
        e = sb.pop_front();
        chk({tag, ".rdy"},   {31'h0, h_ready},  {31'h0, e.rdy});
        chk({tag, ".resp"},  {31'h0, h_resp},   {31'h0, e.resp});
        chk({tag, ".rdata"}, h_rdata,           e.rd);
        chk({tag, ".rdy2"},  {31'h0, h_ready2}, {31'h0, e.rdy});
        chk({tag, ".resp2"}, {31'h0, h_resp2},  {31'h0, e.resp});
        @(posedge h_clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < NS; i++) h_rdata_x[i] = 32'h1000_0000 + i;
        h_rdata_x[2] = 32'hDEAD_BEEF;
        h_reset = 1'b1; err_clr = 1'b0;
        h_sel_x = '0; h_trans = IDLE; h_ready_x = ALL; h_resp_x = '0;
        @(posedge h_clk);
        #1;

        step("rst0", '0, IDLE, ALL, '0, 1, 0, 1, 0, 0);
        step("rst1", '0, IDLE, ALL, '0, 1, 0, 1, 0, 0);
        cnt("rst", 0, 0);

        // slave 2 read
        step("none0", 5'b00100, NONSEQ, ALL, '0, 0, 0, 1, 0, 0);
        step("slv2",  '0,       IDLE,   ALL, '0, 0, 0, 1, 0, 32'hDEAD_BEEF);

        // slave 3 waits 3 cycles while the decoder moves to slave 0
        step("none1", 5'b01000, NONSEQ, ALL, '0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 3; k++)
            step("wait3", 5'b00001, NONSEQ, 5'b10111, '0, 0, 0, 0, 0, RD3);
        step("slv3",  '0, IDLE,   ALL, '0, 0, 0, 1, 0, RD3);

        // unmapped NONSEQ -> two-cycle error
        step("none2", '0, NONSEQ, ALL, '0, 0, 0, 1, 0, 0);
        step("err1",  '0, IDLE,   ALL, '0, 0, 0, 0, 1, 0);
        step("err2",  '0, IDLE,   ALL, '0, 0, 0, 1, 1, 0);
        cnt("err2", 1, 1);
        step("idle",  '0, IDLE,   ALL, '0, 0, 0, 1, 0, 0);
        step("none3", '0, IDLE,   ALL, '0, 0, 0, 1, 0, 0);
        cnt("idle", 1, 1);

        // clear, then back-to-back multi-hot SEQ errors
        step("clr",    5'b00011, SEQ,  ALL, '0, 0, 1, 1, 0, 0);
        cnt("clr", 0, 0);
        step("mh_e1a", 5'b00011, SEQ,  ALL, '0, 0, 0, 0, 1, 0);
        step("mh_e2a", 5'b00011, SEQ,  ALL, '0, 0, 0, 1, 1, 0);
        step("mh_e1b", '0,       IDLE, ALL, '0, 0, 0, 0, 1, 0);
        cnt("mh_a", 1, 1);
        step("mh_e2b", '0,       IDLE, ALL, '0, 0, 0, 1, 1, 0);
        cnt("mh_b", 2, 2);

        // slave 4 error passes through and is counted
        step("mh_done", 5'b10000, NONSEQ, ALL, '0,       0, 0, 1, 0, 0);
        step("slverr",  '0,       NONSEQ, ALL, 5'b10000, 0, 0, 1, 1, RD4);
        cnt("slverr", 3, 3);

        // three more default errors; the 2-bit counter saturates
        for (int k = 0; k < 3; k++) begin
            step("sat_e1", '0, (k < 2) ? NONSEQ : IDLE, ALL, '0, 0, 0, 0, 1, 0);
            step("sat_e2", '0, (k < 2) ? NONSEQ : IDLE, ALL, '0, 0, 0, 1, 1, 0);
        end
        cnt("sat", 6, 3);

        // clear wins over a coincident error completion
        step("c_none", '0, NONSEQ, ALL, '0, 0, 0, 1, 0, 0);
        step("c_e1",   '0, IDLE,   ALL, '0, 0, 0, 0, 1, 0);
        step("c_e2",   '0, IDLE,   ALL, '0, 0, 1, 1, 1, 0);
        cnt("clr_win", 0, 0);

        // reset during a slave wait state aborts it
        step("r_none",  5'b01000, NONSEQ, ALL,      '0, 0, 0, 1, 0, 0);
        step("r_wait",  '0,       IDLE,   5'b10111, '0, 1, 0, 1, 0, 0);
        cnt("r_wait", 0, 0);
        step("r_after", '0,       IDLE,   5'b10111, '0, 0, 0, 1, 0, 0);
        cnt("r_after", 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
